// File: rtl/fmap_pack_writer.sv
// fmap_pack_writer: packs pooled int8 pixels into wide words
// and streams them through a FWFT FIFO to the write DMA.
module fmap_pack_writer #(
  parameter int WIDTH      = 8,
  parameter int PACK       = 8,
  parameter int OUT_COL    = 64,
  parameter int OUT_ROW    = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH*PACK-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DW    = WIDTH * PACK;
  localparam int TOTAL = OUT_COL * OUT_ROW;
  localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [LW-1:0] LANE_MAX = LW'(PACK - 1);
  localparam logic [PW-1:0] PIX_MAX  = PW'(TOTAL - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [LW-1:0] lane_q, lane_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [DW-1:0] pack_q, pack_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          fd_q, fd_d;

  logic   pop;
  logic   push_req;
  logic   push;
  entry_t word;

  // Handshake decode and the word that completes this cycle.
  always_comb begin
    pop       = (level_q != '0) && m_ready;
    push_req  = valid_in && (lane_q == LANE_MAX);
    push      = push_req && ((level_q != LVL_FULL) || pop);
    word.data = pack_q;
    word.data[(PACK-1)*WIDTH +: WIDTH] = din;
    word.last = (pix_q == PIX_MAX);
  end

  // Next state for counters, pack register and FIFO.
  // Counters keep advancing on a drop so m_last stays aligned.
  always_comb begin
    lane_d  = lane_q;
    pix_d   = pix_q;
    pack_d  = pack_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    fd_d    = 1'b0;
    mem_d   = mem_q;
    if (valid_in) begin
      pack_d[lane_q*WIDTH +: WIDTH] = din;
      lane_d = (lane_q == LANE_MAX) ? '0 : lane_q + 1'b1;
      pix_d  = (pix_q == PIX_MAX) ? '0 : pix_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_q] = word;
      wr_d        = wr_q + 1'b1;
    end else if (push_req) begin
      ovf_d = 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
      fd_d = mem_q[rd_q].last;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q  <= '0;
      pix_q   <= '0;
      pack_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      pix_q   <= pix_d;
      pack_q  <= pack_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      fd_q    <= fd_d;
    end
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign m_valid    = (level_q != '0);
  assign m_data     = m_valid ? mem_q[rd_q].data : '0;
  assign m_last     = m_valid ? mem_q[rd_q].last : 1'b0;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_fmap_pack_writer.sv
// tb_fmap_pack_writer: vector table plus queue-based
// reference model for the packer and word FIFO.
module tb_fmap_pack_writer;

  localparam int P   = 8;
  localparam int D   = 16;
  localparam int TOT = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [7:0]  din;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        frame_done;
  logic        overflow;
  logic [4:0]  fifo_level;

  fmap_pack_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .din        (din),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frame_done (frame_done),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } word_t;

  typedef struct {
    bit          r;
    bit          v;
    logic [7:0]  d;
    bit          rdy;
    bit          ev;
    logic [63:0] ed;
    logic [4:0]  el;
  } vec_t;

  word_t      mq[$];
  logic [7:0] pbuf[$];
  word_t      sent[$];
  word_t      rcvd[$];
  int         lastpos[$];
  vec_t       tbl[$];
  int         mpix;
  bit         movf;
  bit         mfd;
  int         words;
  int         fds;
  int         errs;
  int         checks;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40)
        $display("FAIL %s: got %h expected %h",
                 name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit v,
                     input logic [7:0] d, input bit rdy,
                     input bit ev, input logic [63:0] ed,
                     input logic [4:0] el);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.el = el;
    tbl.push_back(t);
  endtask

  task automatic step(input bit r, input bit v,
                      input logic [7:0] d, input bit rdy);
    word_t w;
    bit    pop;
    bit    lastp;
    rst_n    = r;
    valid_in = v;
    din      = d;
    m_ready  = rdy;
    if (r && m_valid === 1'b1 && rdy) begin
      w.last = m_last;
      w.data = m_data;
      rcvd.push_back(w);
      words++;
      if (m_last === 1'b1) lastpos.push_back(words);
    end
    if (!r) begin
      mq.delete();
      pbuf.delete();
      mpix = 0;
      movf = 1'b0;
      mfd  = 1'b0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      mfd = 1'b0;
      if (pop) begin
        mfd = mq[0].last;
        void'(mq.pop_front());
      end
      if (v) begin
        pbuf.push_back(d);
        lastp = (mpix == TOT - 1);
        mpix  = (mpix + 1) % TOT;
        if (pbuf.size() == P) begin
          w.last = lastp;
          for (int i = 0; i < P; i++)
            w.data[8*i +: 8] = pbuf[i];
          sent.push_back(w);
          if (mq.size() < D) mq.push_back(w);
          else movf = 1'b1;
          pbuf.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fds++;
    chk("m_valid", 64'(m_valid), 64'(mq.size() != 0));
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("frame_done", 64'(frame_done), 64'(mfd));
    if (mq.size() != 0) begin
      chk("m_data", m_data, mq[0].data);
      chk("m_last", 64'(m_last), 64'(mq[0].last));
    end
    if (!r) begin
      chk("rst_m_data", m_data, 64'h0);
      chk("rst_m_last", 64'(m_last), 64'h0);
    end
  endtask

  task automatic clear_counts();
    words = 0;
    fds   = 0;
    lastpos.delete();
    rcvd.delete();
    sent.delete();
  endtask

  initial begin
    logic [63:0] e;
    int          sentpix;
    bit          v;
    errs     = 0;
    checks   = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    din      = 8'h00;
    m_ready  = 1'b0;
    clear_counts();

    add(0, 0, 8'h00, 1, 0, 64'h0, 5'd0);
    add(0, 0, 8'h00, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'hAA, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'hBB, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'hCC, 1, 0, 64'h0, 5'd0);
    add(0, 1, 8'hDD, 1, 0, 64'h0, 5'd0);
    add(0, 0, 8'h00, 1, 0, 64'h0, 5'd0);
    for (int i = 0; i < 7; i++)
      add(1, 1, 8'(8'h11 + i), 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'h18, 1, 1, 64'h1817161514131211, 5'd1);
    add(1, 0, 8'h00, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'h01, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'hFF, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'h80, 1, 0, 64'h0, 5'd0);
    add(1, 0, 8'h55, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'h7F, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'h00, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'h02, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'hFE, 1, 0, 64'h0, 5'd0);
    add(1, 1, 8'h10, 1, 1, 64'h10FE02007F80FF01, 5'd1);
    add(1, 0, 8'h00, 1, 0, 64'h0, 5'd0);

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].rdy);
      chk($sformatf("tbl%0d_valid", k),
          64'(m_valid), 64'(tbl[k].ev));
      chk($sformatf("tbl%0d_level", k),
          64'(fifo_level), 64'(tbl[k].el));
      if (tbl[k].ev)
        chk($sformatf("tbl%0d_data", k),
            m_data, tbl[k].ed);
    end

    // two full frames, random gaps, sink always ready
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    clear_counts();
    sentpix = 0;
    while (sentpix < 2 * TOT) begin
      v = ($urandom_range(3) != 0);
      step(1, v, 8'($urandom), 1);
      if (v) sentpix++;
    end
    repeat (4) step(1, 0, 8'h00, 1);
    chk("frame_words", 64'(words), 64'd1024);
    chk("frame_lasts", 64'(lastpos.size()), 64'd2);
    if (lastpos.size() == 2) begin
      chk("frame_last0", 64'(lastpos[0]), 64'd512);
      chk("frame_last1", 64'(lastpos[1]), 64'd1024);
    end
    chk("frame_done_cnt", 64'(fds), 64'd2);
    chk("frame_ovf", 64'(overflow), 64'd0);

    // backpressure overflow then drain and finish frame
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    clear_counts();
    for (int i = 0; i < 136; i++)
      step(1, 1, 8'(i), 0);
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    repeat (20) step(1, 0, 8'h00, 1);
    chk("ovf_drained", 64'(rcvd.size()), 64'd16);
    for (int k = 0; k < 16 && k < rcvd.size(); k++) begin
      for (int j = 0; j < 8; j++)
        e[8*j +: 8] = 8'(8*k + j);
      chk($sformatf("ovf_word%0d", k), rcvd[k].data, e);
    end
    for (int i = 136; i < TOT; i++)
      step(1, 1, 8'($urandom), 1);
    repeat (4) step(1, 0, 8'h00, 1);
    chk("ovf_words", 64'(words), 64'd511);
    chk("ovf_lasts", 64'(lastpos.size()), 64'd1);
    if (lastpos.size() == 1)
      chk("ovf_lastpos", 64'(lastpos[0]), 64'd511);
    chk("ovf_fd_cnt", 64'(fds), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // full FIFO with a pop in the completing cycle
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    clear_counts();
    for (int i = 0; i < 135; i++)
      step(1, 1, 8'(i), 0);
    chk("full_level", 64'(fifo_level), 64'd16);
    step(1, 1, 8'd135, 1);
    chk("fullpop_level", 64'(fifo_level), 64'd16);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    chk("fullpop_head", m_data, 64'h0F0E0D0C0B0A0908);
    repeat (20) step(1, 0, 8'h00, 1);

    // random stalls with streaming words
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    clear_counts();
    repeat (2000)
      step(1, 1'($urandom_range(1)), 8'($urandom),
           1'($urandom_range(1)));
    repeat (40) step(1, 0, 8'h00, 1);
    chk("stall_count", 64'(rcvd.size()), 64'(sent.size()));
    for (int k = 0; k < rcvd.size() && k < sent.size(); k++)
      chk($sformatf("stall_word%0d", k),
          64'(rcvd[k] != sent[k]), 64'd0);
    chk("stall_ovf", 64'(overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
